// File: rtl/cbfp_block_ctrl_if.sv
// ----------------------------------------------------------------------------
// cbfp_block_ctrl_if
//   Bundle of the signals between the CBFP block controller and its
//   environment.
//   master : drives valid_in / zero_cnt_in / rd_stall and observes the rest
//            (butterfly output side plus downstream datapath).
//   slave  : the controller itself.
//   Signals
//     valid_in      one 16-lane beat presented this cycle
//     zero_cnt_in   minimum leading-sign count of the current beat
//     rd_stall      downstream hold, freezes read sequencing
//     wr_en/wr_bank/wr_addr   buffer write strobe, bank and beat index
//     rd_en/rd_bank/rd_addr   buffer read strobe, bank and beat index
//     shift_amt/blk_exp       per-block right shift and exponent
//     valid_out     scaled beat valid at the datapath output
//     overflow_err  sticky flag, set when a beat was dropped
//     busy          any bank full or a read in progress
// ----------------------------------------------------------------------------
interface cbfp_block_ctrl_if #(
    parameter int cnt_size        = 5,
    parameter int beats_per_block = 4
);
    localparam int addr_w = (beats_per_block > 1) ? $clog2(beats_per_block) : 1;

    logic                valid_in;
    logic [cnt_size-1:0] zero_cnt_in;
    logic                rd_stall;
    logic                wr_en;
    logic                wr_bank;
    logic [addr_w-1:0]   wr_addr;
    logic                rd_en;
    logic                rd_bank;
    logic [addr_w-1:0]   rd_addr;
    logic [cnt_size-1:0] shift_amt;
    logic [cnt_size-1:0] blk_exp;
    logic                valid_out;
    logic                overflow_err;
    logic                busy;

    modport master (
        output valid_in, zero_cnt_in, rd_stall,
        input  wr_en, wr_bank, wr_addr, rd_en, rd_bank, rd_addr,
               shift_amt, blk_exp, valid_out, overflow_err, busy
    );

    modport slave (
        input  valid_in, zero_cnt_in, rd_stall,
        output wr_en, wr_bank, wr_addr, rd_en, rd_bank, rd_addr,
               shift_amt, blk_exp, valid_out, overflow_err, busy
    );
endinterface

// File: rtl/cbfp_block_ctrl.sv
// ----------------------------------------------------------------------------
// cbfp_block_ctrl
//   Sequencer for the M0 CBFP stage. Groups input beats into blocks of
//   beats_per_block beats, steers them into a two-bank ping-pong buffer,
//   tracks the block-wide minimum zero count, and replays each completed
//   block with one shift amount / exponent.
//   Ports
//     clk  : clock, rising edge
//     rst  : synchronous active-high reset
//     bus  : cbfp_block_ctrl_if.slave (see interface header for signals)
// ----------------------------------------------------------------------------
module cbfp_block_ctrl #(
    parameter int cnt_size        = 5,
    parameter int din_size        = 23,
    parameter int dout_size       = 11,
    parameter int beats_per_block = 4
) (
    input  logic               clk,
    input  logic               rst,
    cbfp_block_ctrl_if.slave   bus
);
    localparam int addr_w = (beats_per_block > 1) ? $clog2(beats_per_block) : 1;

    localparam logic [0:0] st_idle = 1'b0;
    localparam logic [0:0] st_read = 1'b1;

    localparam logic [cnt_size-1:0] max_shift = cnt_size'(din_size - dout_size);
    localparam logic [addr_w-1:0]   last_addr = addr_w'(beats_per_block - 1);

    // Shift that brings the block's largest sample to the output width,
    // saturating when the block has more headroom than the stage needs.
    function automatic logic [cnt_size-1:0] shift_for(input logic [cnt_size-1:0] m);
        return max_shift - ((m > max_shift) ? max_shift : m);
    endfunction

    logic [0:0]          state_reg, state_next;
    logic                wr_bank_reg;
    logic [addr_w-1:0]   wr_addr_reg;
    logic [cnt_size-1:0] run_min_reg;
    logic                rd_bank_reg, rd_bank_next;
    logic [addr_w-1:0]   rd_addr_reg, rd_addr_next;
    logic [cnt_size-1:0] shift_reg, shift_next;
    logic                valid_out_reg;
    logic                overflow_reg;

    logic                rd_en_c;
    logic                final_read;
    logic                accept;
    logic                wr_en_c;
    logic                blk_done;
    logic [cnt_size-1:0] beat_min;

    logic [1:0]          full;
    logic [1:0]          eff_full;
    logic [cnt_size-1:0] eff_min [2];

    // ------------------------------------------------------------------
    // Write side (combinational strobes)
    // ------------------------------------------------------------------
    assign rd_en_c    = (state_reg == st_read) && !bus.rd_stall;
    assign final_read = rd_en_c && (rd_addr_reg == last_addr);
    // A full bank can take a new beat on the very cycle its last beat is
    // read out, which is what keeps continuous input from overflowing.
    assign accept     = !full[wr_bank_reg] || (final_read && (rd_bank_reg == wr_bank_reg));
    assign wr_en_c    = bus.valid_in && accept;
    assign blk_done   = wr_en_c && (wr_addr_reg == last_addr);
    assign beat_min   = (wr_addr_reg == '0) ? bus.zero_cnt_in :
                        ((run_min_reg < bus.zero_cnt_in) ? run_min_reg : bus.zero_cnt_in);

    // ------------------------------------------------------------------
    // Per-bank full flag and stored block minimum. eff_* also reflect a
    // block completing this cycle so the reader can start without an
    // extra bubble.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : bank_g
        logic                full_reg;
        logic [cnt_size-1:0] min_reg;
        logic                completing;

        assign completing  = blk_done && (wr_bank_reg == 1'(gi));
        assign full[gi]    = full_reg;
        assign eff_full[gi] = full_reg || completing;
        assign eff_min[gi] = completing ? beat_min : min_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                full_reg <= 1'b0;
                min_reg  <= '0;
            end else begin
                // A new block landing wins over the clear of a drained bank.
                if (completing) begin
                    full_reg <= 1'b1;
                    min_reg  <= beat_min;
                end else if (final_read && (rd_bank_reg == 1'(gi))) begin
                    full_reg <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read FSM next-state
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        rd_bank_next = rd_bank_reg;
        rd_addr_next = rd_addr_reg;
        shift_next   = shift_reg;
        case (state_reg)
            st_idle: begin
                if (eff_full[rd_bank_reg] && !bus.rd_stall) begin
                    state_next   = st_read;
                    rd_addr_next = '0;
                    shift_next   = shift_for(eff_min[rd_bank_reg]);
                end
            end
            st_read: begin
                if (rd_en_c) begin
                    if (final_read) begin
                        rd_bank_next = !rd_bank_reg;
                        rd_addr_next = '0;
                        if (eff_full[!rd_bank_reg]) begin
                            shift_next = shift_for(eff_min[!rd_bank_reg]);
                        end else begin
                            state_next = st_idle;
                        end
                    end else begin
                        rd_addr_next = rd_addr_reg + addr_w'(1);
                    end
                end
            end
            default: state_next = st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= st_idle;
            wr_bank_reg   <= 1'b0;
            wr_addr_reg   <= '0;
            run_min_reg   <= '0;
            rd_bank_reg   <= 1'b0;
            rd_addr_reg   <= '0;
            shift_reg     <= '0;
            valid_out_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rd_bank_reg   <= rd_bank_next;
            rd_addr_reg   <= rd_addr_next;
            shift_reg     <= shift_next;
            valid_out_reg <= rd_en_c;
            if (wr_en_c) begin
                run_min_reg <= beat_min;
                if (blk_done) begin
                    wr_addr_reg <= '0;
                    wr_bank_reg <= !wr_bank_reg;
                end else begin
                    wr_addr_reg <= wr_addr_reg + addr_w'(1);
                end
            end
            if (bus.valid_in && !accept) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign bus.wr_en        = wr_en_c;
    assign bus.wr_bank      = wr_bank_reg;
    assign bus.wr_addr      = wr_addr_reg;
    assign bus.rd_en        = rd_en_c;
    assign bus.rd_bank      = rd_bank_reg;
    assign bus.rd_addr      = rd_addr_reg;
    assign bus.shift_amt    = shift_reg;
    assign bus.blk_exp      = shift_reg;
    assign bus.valid_out    = valid_out_reg;
    assign bus.overflow_err = overflow_reg;
    assign bus.busy         = full[0] || full[1] || (state_reg == st_read);
endmodule

// File: tb/tb_cbfp_block_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cbfp_block_ctrl
//   Self-checking bench for cbfp_block_ctrl. A queue-of-blocks reference
//   model predicts every output each cycle; directed scenarios are followed
//   by a randomized run with stalls and occasional resets.
// ----------------------------------------------------------------------------
module tb_cbfp_block_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cbfp_block_ctrl_if bus ();

    cbfp_block_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // blocks  : minima of completed blocks held in the buffer, oldest first
    //           (the block being read, if any, is at the front)
    // partial : zero counts of the block being collected
    int blocks[$];
    int partial[$];
    int blocks_written, blocks_read;
    bit reading;
    int read_idx;
    int m_shift;
    bit m_valid_out, m_ovf;

    function automatic int shift_of(input int m);
        return 12 - ((m > 12) ? 12 : m);
    endfunction

    function automatic int qmin(input int q[$]);
        int r = q[0];
        foreach (q[i]) if (q[i] < r) r = q[i];
        return r;
    endfunction

    task automatic model_reset();
        blocks.delete();
        partial.delete();
        blocks_written = 0;
        blocks_read    = 0;
        reading        = 0;
        read_idx       = 0;
        m_shift        = 0;
        m_valid_out    = 0;
        m_ovf          = 0;
    endtask

    // One clock cycle: drive, compare at the negedge, advance the model.
    task automatic cycle(input bit v, input int zc, input bit st, input bit r);
        bit exp_rd_en, fin, acc, exp_wr_en;
        rst             = r;
        bus.valid_in    = v;
        bus.zero_cnt_in = 5'(zc);
        bus.rd_stall    = st;
        @(negedge clk);
        exp_rd_en = reading && !st;
        fin       = exp_rd_en && (read_idx == 3);
        acc       = (blocks.size() < 2) || fin;
        exp_wr_en = v && acc;
        if (!r) begin
            check("wr_en",        32'(bus.wr_en),        32'(exp_wr_en));
            check("wr_bank",      32'(bus.wr_bank),      32'(blocks_written % 2));
            check("wr_addr",      32'(bus.wr_addr),      32'(partial.size()));
            check("rd_en",        32'(bus.rd_en),        32'(exp_rd_en));
            check("rd_bank",      32'(bus.rd_bank),      32'(blocks_read % 2));
            check("rd_addr",      32'(bus.rd_addr),      32'(read_idx));
            check("shift_amt",    32'(bus.shift_amt),    32'(m_shift));
            check("blk_exp",      32'(bus.blk_exp),      32'(m_shift));
            check("valid_out",    32'(bus.valid_out),    32'(m_valid_out));
            check("overflow_err", 32'(bus.overflow_err), 32'(m_ovf));
            check("busy",         32'(bus.busy),         32'((blocks.size() > 0) || reading));
        end
        if (r) begin
            model_reset();
        end else begin
            if (exp_wr_en) begin
                partial.push_back(zc);
                if (partial.size() == 4) begin
                    blocks.push_back(qmin(partial));
                    partial.delete();
                    blocks_written++;
                end
            end
            if (v && !acc) m_ovf = 1;
            m_valid_out = exp_rd_en;
            if (reading) begin
                if (exp_rd_en) begin
                    read_idx++;
                    if (read_idx == 4) begin
                        void'(blocks.pop_front());
                        blocks_read++;
                        read_idx = 0;
                        if (blocks.size() > 0) m_shift = shift_of(blocks[0]);
                        else reading = 0;
                    end
                end
            end else if ((blocks.size() > 0) && !st) begin
                reading  = 1;
                read_idx = 0;
                m_shift  = shift_of(blocks[0]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
    endtask

    int seq1[4];
    int mins4[16];
    int gap_pat[10];

    initial begin
        model_reset();
        bus.valid_in    = 0;
        bus.zero_cnt_in = '0;
        bus.rd_stall    = 0;
        rst             = 1;

        // Reset state
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        idle(1);
        check("rst_busy_const", 32'(bus.busy), 32'(0));
        $display("reset done");

        // Single block 7,5,9,6 -> shift 12-5 = 7
        seq1 = '{7, 5, 9, 6};
        for (int i = 0; i < 4; i++) cycle(1, seq1[i], 0, 0);
        idle(8);
        check("single_shift_const", 32'(bus.shift_amt), 32'(7));
        $display("single block: shift_amt=%0d", bus.shift_amt);

        // Four blocks 4 on / 4 off, minima 3,12,15,0
        mins4 = '{5, 3, 8, 4,  12, 14, 13, 20,  15, 31, 20, 16,  0, 5, 6, 7};
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 4; i++) cycle(1, mins4[b*4+i], 0, 0);
            idle(4);
            $display("block %0d: shift_amt=%0d", b, bus.shift_amt);
        end
        idle(4);
        check("four_blocks_no_ovf", 32'(bus.overflow_err), 32'(0));

        // Mid-block gap: beats at relative cycles 0,1,5,9
        gap_pat = '{1, 1, 0, 0, 0, 1, 0, 0, 0, 1};
        for (int i = 0; i < 10; i++) cycle(gap_pat[i], 10 - i, 0, 0);
        idle(8);
        $display("gap block: shift_amt=%0d", bus.shift_amt);

        // 12 continuous beats
        for (int i = 0; i < 12; i++) cycle(1, $urandom_range(0, 20), 0, 0);
        idle(10);
        $display("continuous 12 beats done");

        // Stall for 20 cycles under continuous input, then release
        for (int i = 0; i < 20; i++) cycle(1, $urandom_range(0, 31), 1, 0);
        idle(14);
        check("stall_ovf_sticky_const", 32'(bus.overflow_err), 32'(1));
        $display("stall: overflow_err=%0d", bus.overflow_err);

        // Reset mid-block, then a fresh block
        cycle(1, 4, 0, 0);
        cycle(1, 2, 0, 0);
        cycle(1, 9, 0, 1);
        idle(1);
        check("rst_ovf_clear_const", 32'(bus.overflow_err), 32'(0));
        for (int i = 0; i < 4; i++) cycle(1, 8 + i, 0, 0);
        idle(8);
        $display("after mid-block reset: shift_amt=%0d", bus.shift_amt);

        // Randomized traffic with stalls and rare resets
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 9) < 7), $urandom_range(0, 31),
                  ($urandom_range(0, 9) < 3), ($urandom_range(0, 199) == 0));
        end
        idle(12);
        $display("random traffic done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
